// File: rtl/beat_fetch_sequencer.sv
// Tempo-driven instruction fetch controller: generates the beat tick, reads one SRAM word per
// beat at the program counter and hands it to the decoder over a valid/ready handshake.
module beat_fetch_sequencer #(
  parameter int unsigned ADDR_W      = 18,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned CPB_W       = 32,
  parameter int unsigned DEFAULT_CPB = 31_250_000,
  parameter int unsigned READ_WAIT   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run_i,
  input  logic              cpb_load_i,
  input  logic [CPB_W-1:0]  cpb_val_i,
  input  logic              jump_i,
  input  logic [ADDR_W-1:0] jump_addr_i,
  output logic [ADDR_W-1:0] sram_addr_o,
  output logic              sram_ce_n_o,
  output logic              sram_oe_n_o,
  output logic              sram_we_n_o,
  input  logic [DATA_W-1:0] sram_dq_i,
  output logic              ins_valid_o,
  input  logic              ins_ready_i,
  output logic [DATA_W-1:0] ins_data_o,
  output logic [ADDR_W-1:0] ins_addr_o,
  output logic              beat_o,
  output logic              overrun_o
);

  localparam int unsigned WAIT_W = (READ_WAIT > 1) ? $clog2(READ_WAIT) : 1;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_WAIT_BEAT = 3'd1;
  localparam logic [2:0] S_ADDR      = 3'd2;
  localparam logic [2:0] S_READ      = 3'd3;
  localparam logic [2:0] S_HOLD      = 3'd4;

  logic [2:0]        state_q,   state_d;
  logic [ADDR_W-1:0] pc_q,      pc_d;
  logic [CPB_W-1:0]  cpb_q,     cpb_d;
  logic [CPB_W-1:0]  cnt_q,     cnt_d;
  logic [WAIT_W-1:0] wait_q,    wait_d;
  logic [ADDR_W-1:0] saddr_q,   saddr_d;
  logic              ce_n_q,    ce_n_d;
  logic              oe_n_q,    oe_n_d;
  logic              valid_q,   valid_d;
  logic [DATA_W-1:0] data_q,    data_d;
  logic [ADDR_W-1:0] iaddr_q,   iaddr_d;
  logic              beat_q,    beat_d;
  logic              overrun_q, overrun_d;
  logic              busy;

  // Beat timer: a reload restarts the period and suppresses the pending beat
  always_comb begin
    cpb_d  = cpb_q;
    cnt_d  = cnt_q;
    beat_d = 1'b0;
    if (cpb_load_i) begin
      cpb_d = (cpb_val_i == '0) ? CPB_W'(1) : cpb_val_i;
      cnt_d = '0;
    end else if (!run_i) begin
      cnt_d = '0;
    end else if (cnt_q == cpb_q - CPB_W'(1)) begin
      cnt_d  = '0;
      beat_d = 1'b1;
    end else begin
      cnt_d = cnt_q + CPB_W'(1);
    end
  end

  assign busy = (state_q == S_ADDR) || (state_q == S_READ) || (state_q == S_HOLD);

  // Fetch FSM next-state and datapath
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    wait_d    = wait_q;
    saddr_d   = saddr_q;
    ce_n_d    = ce_n_q;
    oe_n_d    = oe_n_q;
    valid_d   = valid_q;
    data_d    = data_q;
    iaddr_d   = iaddr_q;
    overrun_d = beat_q && busy;

    if (!run_i) begin
      state_d = S_IDLE;
      valid_d = 1'b0;
      ce_n_d  = 1'b1;
      oe_n_d  = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: state_d = S_ADDR;
        S_WAIT_BEAT: begin
          if (beat_q) state_d = S_ADDR;
        end
        S_ADDR: begin
          saddr_d = pc_q;
          ce_n_d  = 1'b0;
          oe_n_d  = 1'b0;
          wait_d  = WAIT_W'(READ_WAIT - 1);
          state_d = S_READ;
        end
        S_READ: begin
          if (wait_q == '0) begin
            data_d  = sram_dq_i;
            iaddr_d = saddr_q;
            valid_d = 1'b1;
            ce_n_d  = 1'b1;
            oe_n_d  = 1'b1;
            pc_d    = pc_q + ADDR_W'(1);
            state_d = S_HOLD;
          end else begin
            wait_d = wait_q - WAIT_W'(1);
          end
        end
        S_HOLD: begin
          if (valid_q && ins_ready_i) begin
            valid_d = 1'b0;
            state_d = S_WAIT_BEAT;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    // A jump overrides the post-read increment
    if (jump_i) pc_d = jump_addr_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      cpb_q     <= CPB_W'(DEFAULT_CPB);
      cnt_q     <= '0;
      wait_q    <= '0;
      saddr_q   <= '0;
      ce_n_q    <= 1'b1;
      oe_n_q    <= 1'b1;
      valid_q   <= 1'b0;
      data_q    <= '0;
      iaddr_q   <= '0;
      beat_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      cpb_q     <= cpb_d;
      cnt_q     <= cnt_d;
      wait_q    <= wait_d;
      saddr_q   <= saddr_d;
      ce_n_q    <= ce_n_d;
      oe_n_q    <= oe_n_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
      iaddr_q   <= iaddr_d;
      beat_q    <= beat_d;
      overrun_q <= overrun_d;
    end
  end

  assign sram_addr_o = saddr_q;
  assign sram_ce_n_o = ce_n_q;
  assign sram_oe_n_o = oe_n_q;
  assign sram_we_n_o = 1'b1;
  assign ins_valid_o = valid_q;
  assign ins_data_o  = data_q;
  assign ins_addr_o  = iaddr_q;
  assign beat_o      = beat_q;
  assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_beat_fetch_sequencer.sv
// Directed bench for beat_fetch_sequencer (cpb=8, READ_WAIT=2, SRAM returns addr ^ 16'hA5A5).
module tb_beat_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run;
  logic        cpb_load;
  logic [31:0] cpb_val;
  logic        jump;
  logic [17:0] jump_addr;
  logic [17:0] sram_addr;
  logic        sram_ce_n, sram_oe_n, sram_we_n;
  logic [15:0] sram_dq;
  logic        ins_valid, ins_ready;
  logic [15:0] ins_data;
  logic [17:0] ins_addr;
  logic        beat, overrun;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned cyc      = 0;

  typedef struct {
    int unsigned cyc;
    logic        run;
    logic        ready;
    logic        valid;
    logic [15:0] data;
    logic [17:0] iaddr;
    logic [17:0] saddr;
    logic        ce_n;
    logic        oe_n;
    logic        beat;
    logic        ovr;
  } vec_t;

  vec_t vecs[17];

  beat_fetch_sequencer #(
    .ADDR_W(18), .DATA_W(16), .CPB_W(32), .DEFAULT_CPB(8), .READ_WAIT(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .run_i(run), .cpb_load_i(cpb_load), .cpb_val_i(cpb_val),
    .jump_i(jump), .jump_addr_i(jump_addr), .sram_addr_o(sram_addr), .sram_ce_n_o(sram_ce_n),
    .sram_oe_n_o(sram_oe_n), .sram_we_n_o(sram_we_n), .sram_dq_i(sram_dq),
    .ins_valid_o(ins_valid), .ins_ready_i(ins_ready), .ins_data_o(ins_data),
    .ins_addr_o(ins_addr), .beat_o(beat), .overrun_o(overrun)
  );

  always #5 clk = ~clk;

  assign sram_dq = sram_addr[15:0] ^ 16'hA5A5;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int unsigned c);
    while (cyc < c) step();
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " valid"},   32'(ins_valid), 32'd0);
    chk({tag, " data"},    32'(ins_data),  32'd0);
    chk({tag, " iaddr"},   32'(ins_addr),  32'd0);
    chk({tag, " saddr"},   32'(sram_addr), 32'd0);
    chk({tag, " ce_n"},    32'(sram_ce_n), 32'd1);
    chk({tag, " oe_n"},    32'(sram_oe_n), 32'd1);
    chk({tag, " we_n"},    32'(sram_we_n), 32'd1);
    chk({tag, " beat"},    32'(beat),      32'd0);
    chk({tag, " overrun"}, 32'(overrun),   32'd0);
  endtask

  function automatic vec_t mk(input int unsigned c, input logic r, input logic rd,
                              input logic v, input logic [15:0] d, input logic [17:0] ia,
                              input logic [17:0] sa, input logic ce, input logic oe,
                              input logic b, input logic o);
    vec_t t;
    t.cyc = c; t.run = r; t.ready = rd; t.valid = v; t.data = d; t.iaddr = ia;
    t.saddr = sa; t.ce_n = ce; t.oe_n = oe; t.beat = b; t.ovr = o;
    return t;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Fetch cadence and stalled handshake, checked at chosen cycles
    vecs[0]  = mk(2,  1'b1, 1'b1, 1'b0, 16'h0000, 18'h0, 18'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    vecs[1]  = mk(4,  1'b1, 1'b1, 1'b1, 16'hA5A5, 18'h0, 18'h0, 1'b1, 1'b1, 1'b0, 1'b0);
    vecs[2]  = mk(5,  1'b1, 1'b1, 1'b0, 16'hA5A5, 18'h0, 18'h0, 1'b1, 1'b1, 1'b0, 1'b0);
    vecs[3]  = mk(8,  1'b1, 1'b1, 1'b0, 16'hA5A5, 18'h0, 18'h0, 1'b1, 1'b1, 1'b1, 1'b0);
    vecs[4]  = mk(10, 1'b1, 1'b1, 1'b0, 16'hA5A5, 18'h0, 18'h1, 1'b0, 1'b0, 1'b0, 1'b0);
    vecs[5]  = mk(12, 1'b1, 1'b1, 1'b1, 16'hA5A4, 18'h1, 18'h1, 1'b1, 1'b1, 1'b0, 1'b0);
    vecs[6]  = mk(16, 1'b1, 1'b1, 1'b0, 16'hA5A4, 18'h1, 18'h1, 1'b1, 1'b1, 1'b1, 1'b0);
    vecs[7]  = mk(20, 1'b1, 1'b1, 1'b1, 16'hA5A7, 18'h2, 18'h2, 1'b1, 1'b1, 1'b0, 1'b0);
    vecs[8]  = mk(28, 1'b1, 1'b1, 1'b1, 16'hA5A6, 18'h3, 18'h3, 1'b1, 1'b1, 1'b0, 1'b0);
    vecs[9]  = mk(29, 1'b1, 1'b1, 1'b0, 16'hA5A6, 18'h3, 18'h3, 1'b1, 1'b1, 1'b0, 1'b0);
    vecs[10] = mk(36, 1'b1, 1'b0, 1'b1, 16'hA5A1, 18'h4, 18'h4, 1'b1, 1'b1, 1'b0, 1'b0);
    vecs[11] = mk(40, 1'b1, 1'b0, 1'b1, 16'hA5A1, 18'h4, 18'h4, 1'b1, 1'b1, 1'b1, 1'b0);
    vecs[12] = mk(41, 1'b1, 1'b0, 1'b1, 16'hA5A1, 18'h4, 18'h4, 1'b1, 1'b1, 1'b0, 1'b1);
    vecs[13] = mk(49, 1'b1, 1'b0, 1'b1, 16'hA5A1, 18'h4, 18'h4, 1'b1, 1'b1, 1'b0, 1'b1);
    vecs[14] = mk(50, 1'b1, 1'b1, 1'b0, 16'hA5A1, 18'h4, 18'h4, 1'b1, 1'b1, 1'b0, 1'b0);
    vecs[15] = mk(56, 1'b1, 1'b1, 1'b0, 16'hA5A1, 18'h4, 18'h4, 1'b1, 1'b1, 1'b1, 1'b0);
    vecs[16] = mk(60, 1'b1, 1'b1, 1'b1, 16'hA5A0, 18'h5, 18'h5, 1'b1, 1'b1, 1'b0, 1'b0);

    rst_n = 1'b0; run = 1'b0; cpb_load = 1'b0; cpb_val = '0;
    jump = 1'b0; jump_addr = '0; ins_ready = 1'b0;
    #22 rst_n = 1'b1;
    @(posedge clk);
    #1;
    cyc = 0;
    chk_reset("reset");

    for (int i = 0; i < 17; i++) begin
      run = vecs[i].run;
      ins_ready = vecs[i].ready;
      run_to(vecs[i].cyc);
      chk($sformatf("v%0d valid", i),   32'(ins_valid), 32'(vecs[i].valid));
      chk($sformatf("v%0d data", i),    32'(ins_data),  32'(vecs[i].data));
      chk($sformatf("v%0d iaddr", i),   32'(ins_addr),  32'(vecs[i].iaddr));
      chk($sformatf("v%0d saddr", i),   32'(sram_addr), 32'(vecs[i].saddr));
      chk($sformatf("v%0d ce_n", i),    32'(sram_ce_n), 32'(vecs[i].ce_n));
      chk($sformatf("v%0d oe_n", i),    32'(sram_oe_n), 32'(vecs[i].oe_n));
      chk($sformatf("v%0d we_n", i),    32'(sram_we_n), 32'd1);
      chk($sformatf("v%0d beat", i),    32'(beat),      32'(vecs[i].beat));
      chk($sformatf("v%0d overrun", i), 32'(overrun),   32'(vecs[i].ovr));
    end

    // Jump to the top address during WAIT_BEAT, then wrap to 0
    run_to(61);
    jump = 1'b1; jump_addr = 18'h3FFFF;
    run_to(62);
    jump = 1'b0;
    run_to(68);
    chk("jump valid", 32'(ins_valid), 32'd1);
    chk("jump iaddr", 32'(ins_addr),  32'h3FFFF);
    chk("jump data",  32'(ins_data),  32'h5A5A);
    run_to(76);
    chk("wrap valid", 32'(ins_valid), 32'd1);
    chk("wrap iaddr", 32'(ins_addr),  32'h0);
    chk("wrap data",  32'(ins_data),  32'hA5A5);

    // Tempo reload: 0 acts as 1, then 3
    run_to(77);
    cpb_load = 1'b1; cpb_val = 32'd0;
    run_to(78);
    cpb_load = 1'b0;
    chk("cpb1 beat c78", 32'(beat), 32'd0);
    run_to(79); chk("cpb1 beat c79", 32'(beat), 32'd1);
    run_to(80); chk("cpb1 beat c80", 32'(beat), 32'd1);
    run_to(81); chk("cpb1 beat c81", 32'(beat), 32'd1);
    chk("cpb1 overrun c81", 32'(overrun), 32'd1);
    run_to(82);
    cpb_load = 1'b1; cpb_val = 32'd3;
    run_to(83);
    cpb_load = 1'b0;
    chk("cpb1 fetch iaddr", 32'(ins_addr), 32'h1);
    for (int c = 83; c <= 89; c++) begin
      run_to(c);
      chk($sformatf("cpb3 beat c%0d", c), 32'(beat), 32'((c == 86) || (c == 89)));
    end
    run_to(90);
    chk("cpb3 fetch valid", 32'(ins_valid), 32'd1);
    chk("cpb3 fetch iaddr", 32'(ins_addr),  32'h2);

    // Drop run mid-READ, then refetch the same pc
    run_to(94);
    chk("read ce_n",  32'(sram_ce_n), 32'd0);
    chk("read saddr", 32'(sram_addr), 32'h3);
    run = 1'b0;
    run_to(95);
    chk("stop ce_n",  32'(sram_ce_n), 32'd1);
    chk("stop oe_n",  32'(sram_oe_n), 32'd1);
    chk("stop valid", 32'(ins_valid), 32'd0);
    chk("stop beat",  32'(beat),      32'd0);
    run_to(96);
    run = 1'b1; ins_ready = 1'b0;
    run_to(100);
    chk("refetch valid", 32'(ins_valid), 32'd1);
    chk("refetch iaddr", 32'(ins_addr),  32'h3);
    chk("refetch data",  32'(ins_data),  32'hA5A6);

    // Asynchronous reset while holding an instruction
    #2 rst_n = 1'b0;
    run = 1'b0;
    #1;
    chk_reset("async");
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    cyc = 0;
    run = 1'b1; ins_ready = 1'b1;
    run_to(4);
    chk("post-reset valid", 32'(ins_valid), 32'd1);
    chk("post-reset iaddr", 32'(ins_addr),  32'h0);
    chk("post-reset data",  32'(ins_data),  32'hA5A5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
